// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI encodings and FSM types for the SRAM-backed AXI3 slave.
// Burst/response codes follow the AXI3 wire encodings.
package axi_sram_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_RD_RESP,
        ST_WR_DATA,
        ST_WR_RESP
    } state_t;

    typedef enum logic {
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 five-channel bundle between a master and the SRAM slave.
// Sideband lock/cache/prot and wid are carried but not interpreted by the slave.
interface axi_sram_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_slv_addr_gen.sv
// Combinational next-beat address and SRAM range decode for the latched burst address.
// WRAP is treated as INCR; the 32-bit sum wraps naturally with no 4KB boundary check.
module axi_slv_addr_gen
    import axi_sram_slave_pkg::*;
#(
    parameter int RAM_AW = 16
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        in_range
);

    assign next_addr = (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
    assign in_range  = (addr[31:RAM_AW+2] == '0);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave: one burst in service at a time against a single-port word SRAM, read/write tie alternates.
// Reads take 3 cycles per beat (first rvalid 3 cycles after AR), writes 1 beat/cycle; ready/valid stalls hold state.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int RAM_AW = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_sram_slave_if.slave   axi,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t          state_q, state_d;
    grant_t          grant_q, grant_d;
    resp_t           err_q, err_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     addr_nxt;
    logic            in_range;
    logic            last_beat;
    logic            ar_go, aw_go;
    logic            unused_sideband;

    axi_slv_addr_gen #(.RAM_AW(RAM_AW)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (addr_nxt),
        .in_range  (in_range)
    );

    // A read wins a tie unless the previous grant went to a read.
    assign ar_go = (state_q == ST_IDLE) && axi.arvalid && (!axi.awvalid || grant_q == GRANT_WRITE);
    assign aw_go = (state_q == ST_IDLE) && axi.awvalid && (!axi.arvalid || grant_q == GRANT_READ);

    assign last_beat   = (beat_q == len_q);
    assign ram_addr    = addr_q[RAM_AW+1:2];
    assign axi.arready = ar_go;
    assign axi.awready = aw_go;
    assign axi.wready  = (state_q == ST_WR_DATA);
    assign axi.rvalid  = (state_q == ST_RD_RESP);
    assign axi.rlast   = (state_q == ST_RD_RESP) && last_beat;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = err_q;
    assign axi.rid     = id_q;
    assign axi.bvalid  = (state_q == ST_WR_RESP);
    assign axi.bresp   = err_q;
    assign axi.bid     = id_q;

    assign unused_sideband = ^{axi.arlock, axi.arcache, axi.arprot,
                               axi.awlock, axi.awcache, axi.awprot, axi.wid};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_WRITE;
            err_q   <= RESP_OKAY;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        err_d     = err_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        burst_d   = burst_q;
        rdata_d   = rdata_q;
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_wdata = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (ar_go) begin
                    id_d    = axi.arid;
                    addr_d  = axi.araddr;
                    len_d   = axi.arlen;
                    size_d  = axi.arsize;
                    burst_d = axi.arburst;
                    beat_d  = 8'd0;
                    err_d   = RESP_OKAY;
                    grant_d = GRANT_READ;
                    state_d = ST_RD_REQ;
                end else if (aw_go) begin
                    id_d    = axi.awid;
                    addr_d  = axi.awaddr;
                    len_d   = axi.awlen;
                    size_d  = axi.awsize;
                    burst_d = axi.awburst;
                    beat_d  = 8'd0;
                    err_d   = RESP_OKAY;
                    grant_d = GRANT_WRITE;
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_REQ: begin
                ram_en  = in_range;
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                rdata_d = in_range ? ram_rdata : 32'h0;
                err_d   = in_range ? RESP_OKAY : RESP_DECERR;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (axi.rready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_nxt;
                        beat_d  = beat_q + 8'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR_DATA: begin
                if (axi.wvalid) begin
                    ram_en    = in_range;
                    ram_we    = in_range ? axi.wstrb : 4'h0;
                    ram_wdata = axi.wdata;
                    // DECERR is sticky and outranks a wlast/len disagreement.
                    if (!in_range) begin
                        err_d = RESP_DECERR;
                    end else if ((axi.wlast != last_beat) && (err_q != RESP_DECERR)) begin
                        err_d = RESP_SLVERR;
                    end
                    if (last_beat) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        addr_d = addr_nxt;
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (axi.bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
